// File: rtl/breg_pkg.sv
// Shared types and widths for the register-bank write arbiter.
`default_nettype none

package breg_pkg;
  localparam int LARG_END       = 5;
  localparam int NUM_REGS       = 32;
  localparam int LARG_DADO_BREG = 32;
  localparam int LARG_ESCRITA   = LARG_END + LARG_DADO_BREG;

  typedef struct packed {
    logic [LARG_END-1:0]       regd;
    logic [LARG_DADO_BREG-1:0] dado;
  } escrita_t;
endpackage

`default_nettype wire

// File: rtl/fila_escrita.sv
// Synchronous in-order FIFO holding pending multicycle-unit bank writes.
`default_nettype none

module fila_escrita
  import breg_pkg::*;
#(
  parameter int PROF_FILA = 2
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [LARG_ESCRITA-1:0] dado_i,
  output logic [LARG_ESCRITA-1:0] cabeca_o,
  output logic                    cheio_o,
  output logic                    vazio_o
);
  localparam int LARG_PTR  = (PROF_FILA > 1) ? $clog2(PROF_FILA) : 1;
  localparam int LARG_CONT = $clog2(PROF_FILA + 1);
  localparam logic [LARG_PTR-1:0]  ULT_PTR  = LARG_PTR'(PROF_FILA - 1);
  localparam logic [LARG_CONT-1:0] CONT_MAX = LARG_CONT'(PROF_FILA);

  logic [LARG_ESCRITA-1:0] mem_q [PROF_FILA];
  logic [LARG_PTR-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LARG_PTR-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LARG_CONT-1:0]    cont_q, cont_d;
  logic                    push_ok, pop_ok;

  assign cheio_o  = (cont_q == CONT_MAX);
  assign vazio_o  = (cont_q == '0);
  assign push_ok  = push_i && !cheio_o;
  assign pop_ok   = pop_i && !vazio_o;
  assign cabeca_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cont_d   = cont_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == ULT_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == ULT_PTR) ? '0 : rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   cont_d = cont_q + 1'b1;
      2'b01:   cont_d = cont_q - 1'b1;
      default: cont_d = cont_q;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cont_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cont_q   <= cont_d;
    end
  end

  // Storage carries no reset: occupancy is tracked solely by cont_q.
  always_ff @(posedge clock_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= dado_i;
  end
endmodule

`default_nettype wire

// File: rtl/arbitro_escrita_bregs.sv
// Register-bank write-port arbiter: WB priority, buffered MC results, busy scoreboard.
// Optional BREG_CONTADORES_EN adds conflict/forced-cycle counters.
`default_nettype none

module arbitro_escrita_bregs
  import breg_pkg::*;
#(
  parameter int PROF_FILA  = 2,
  parameter int MAX_ESPERA = 4,
  parameter int LARG_DADO  = 32
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 wb_valido_i,
  input  logic [LARG_END-1:0]  wb_regd_i,
  input  logic [LARG_DADO-1:0] wb_dado_i,
  output logic                 wb_pronto_o,
  input  logic                 mc_valido_i,
  input  logic [LARG_END-1:0]  mc_regd_i,
  input  logic [LARG_DADO-1:0] mc_dado_i,
  output logic                 mc_pronto_o,
  input  logic                 marca_valido_i,
  input  logic [LARG_END-1:0]  marca_regd_i,
  input  logic [LARG_END-1:0]  end1_i,
  input  logic [LARG_END-1:0]  end2_i,
  input  logic                 usa1_i,
  input  logic                 usa2_i,
  output logic                 trava_leitura_o,
  output logic                 trava_emissao_o,
  output logic                 reg_escrita_o,
  output logic [LARG_END-1:0]  endereco_regd_o,
  output logic [LARG_DADO-1:0] dado_escrita_o
`ifdef BREG_CONTADORES_EN
  ,
  output logic [31:0]          cont_conflito_o,
  output logic [31:0]          cont_forcado_o
`endif
);
  localparam int LARG_ESP = $clog2(MAX_ESPERA + 1);
  localparam logic [LARG_ESP-1:0] ESP_MAX = LARG_ESP'(MAX_ESPERA);

  escrita_t              entrada, cabeca;
  logic [LARG_ESCRITA-1:0] cabeca_bits;
  logic                  cheio, vazio;
  logic                  mc_aceita, enfileira, drena;
  logic                  wb_quer, forca_mc, sel_wb, sel_mc;
  logic [LARG_ESP-1:0]   espera_q, espera_d;
  logic [NUM_REGS-1:0]   ocupado_q, ocupado_d;

  assign entrada.regd = mc_regd_i;
  assign entrada.dado = mc_dado_i;
  assign cabeca       = escrita_t'(cabeca_bits);

  fila_escrita #(
    .PROF_FILA(PROF_FILA)
  ) u_fila (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .push_i  (enfileira),
    .pop_i   (drena),
    .dado_i  (entrada),
    .cabeca_o(cabeca_bits),
    .cheio_o (cheio),
    .vazio_o (vazio)
  );

  assign mc_pronto_o = !cheio;
  assign mc_aceita   = mc_valido_i && mc_pronto_o;
  assign enfileira   = mc_aceita && (mc_regd_i != '0);

  // A WB to x0 is accepted but never claims the port, leaving it to MC.
  assign wb_quer     = wb_valido_i && (wb_regd_i != '0);
  assign forca_mc    = (espera_q >= ESP_MAX) && !vazio;
  assign wb_pronto_o = !forca_mc;
  assign sel_mc      = !reset_i && (forca_mc || (!wb_quer && !vazio));
  assign sel_wb      = !reset_i && !forca_mc && wb_quer;
  assign drena       = sel_mc;

  always_comb begin
    reg_escrita_o   = 1'b0;
    endereco_regd_o = '0;
    dado_escrita_o  = '0;
    if (sel_mc) begin
      reg_escrita_o   = 1'b1;
      endereco_regd_o = cabeca.regd;
      dado_escrita_o  = cabeca.dado;
    end else if (sel_wb) begin
      reg_escrita_o   = 1'b1;
      endereco_regd_o = wb_regd_i;
      dado_escrita_o  = wb_dado_i;
    end
  end

  always_comb begin
    espera_d = espera_q;
    if (vazio || drena)       espera_d = '0;
    else if (espera_q < ESP_MAX) espera_d = espera_q + 1'b1;
  end

  // Clear is applied first so a same-cycle mark of the drained register wins.
  always_comb begin
    ocupado_d = ocupado_q;
    if (drena) ocupado_d[cabeca.regd] = 1'b0;
    if (marca_valido_i && (marca_regd_i != '0)) ocupado_d[marca_regd_i] = 1'b1;
  end

  assign trava_leitura_o = (usa1_i && ocupado_q[end1_i]) || (usa2_i && ocupado_q[end2_i]);
  assign trava_emissao_o = marca_valido_i && ocupado_q[marca_regd_i];

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      espera_q  <= '0;
      ocupado_q <= '0;
    end else begin
      espera_q  <= espera_d;
      ocupado_q <= ocupado_d;
    end
  end

`ifdef BREG_CONTADORES_EN
  logic [31:0] cont_conflito_q, cont_forcado_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cont_conflito_q <= '0;
      cont_forcado_q  <= '0;
    end else begin
      if (wb_quer && !vazio) cont_conflito_q <= cont_conflito_q + 32'd1;
      if (forca_mc)          cont_forcado_q  <= cont_forcado_q + 32'd1;
    end
  end

  assign cont_conflito_o = cont_conflito_q;
  assign cont_forcado_o  = cont_forcado_q;
`endif
endmodule

`default_nettype wire
